// File: rtl/signed_accumulator.sv
// rtl/signed_accumulator.sv - frame accumulator summing COUNT signed 8-bit samples with sticky overflow
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   clear        synchronous abort of the current frame (wins over any handshake)
//   in_valid     in_data holds a sample
//   in_ready     block accepts a sample this cycle (high in ACCUM)
//   in_data      two's-complement sample
//   out_valid    frame result available (high in DONE)
//   out_ready    consumer takes the result this cycle
//   out_sum      frame sum modulo 2^8, zero while out_valid is low
//   out_overflow sticky signed-overflow flag, zero while out_valid is low
//   busy         a frame is in progress with at least one sample accepted
module signed_accumulator #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_overflow,
  output logic       busy
);

  typedef enum logic {ACCUM, DONE} state_t;

  // Counter is sized for the largest legal COUNT (15).
  localparam logic [3:0] LAST = 4'(COUNT - 1);

  state_t     state;
  logic [7:0] acc;
  logic       ovf;
  logic [3:0] cnt;

  logic [7:0] sum_next;
  logic       ovf_step;

  assign sum_next = acc + in_data;
  // Signed overflow: operands share a sign and the result's sign differs.
  assign ovf_step = (acc[7] == in_data[7]) && (sum_next[7] != acc[7]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= 8'h00;
      ovf   <= 1'b0;
      cnt   <= 4'd0;
    end else if (clear) begin
      state <= ACCUM;
      acc   <= 8'h00;
      ovf   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= sum_next;
            ovf <= ovf | ovf_step;
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= 8'h00;
            ovf   <= 1'b0;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == DONE);
  assign out_sum      = out_valid ? acc : 8'h00;
  assign out_overflow = out_valid & ovf;
  assign busy         = (state == ACCUM) && (cnt != 4'd0);

endmodule

// File: tb/tb_signed_accumulator.sv
// tb/tb_signed_accumulator.sv - directed self-checking bench for signed_accumulator (COUNT=4)
module tb_signed_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  signed_accumulator #(.COUNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_overflow(out_overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      sum;
    logic            ovf;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(int a, int b, int c, int d, int sum, bit ovf);
    vec_t v;
    v.s[0] = 8'(a);
    v.s[1] = 8'(b);
    v.s[2] = 8'(c);
    v.s[3] = 8'(d);
    v.sum  = 8'(sum);
    v.ovf  = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Feed four samples, verify the DONE result, then hand it off.
  task automatic run_frame(input string name, input vec_t v);
    for (int i = 0; i < 4; i++) begin
      check({name, " in_ready"}, 8'(in_ready), 8'd1);
      accept(v.s[i]);
      if (i == 0) check({name, " busy"}, 8'(busy), 8'd1);
    end
    check({name, " out_valid"}, 8'(out_valid), 8'd1);
    check({name, " out_sum"}, out_sum, v.sum);
    check({name, " out_overflow"}, 8'(out_overflow), 8'(v.ovf));
    check({name, " in_ready done"}, 8'(in_ready), 8'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid after hs"}, 8'(out_valid), 8'd0);
    check({name, " in_ready after hs"}, 8'(in_ready), 8'd1);
  endtask

  initial begin
    tbl[0] = mk(10, 20, 30, 40, 8'h64, 1'b0);
    tbl[1] = mk(100, 50, -100, 0, 8'h32, 1'b1);
    tbl[2] = mk(-128, -1, 1, 0, 8'h80, 1'b1);
    tbl[3] = mk(127, 1, 0, 0, 8'h80, 1'b1);
    tbl[4] = mk(-1, -1, -1, -1, 8'hFC, 1'b0);
    tbl[5] = mk(127, 0, 0, 0, 8'h7F, 1'b0);

    // Reset state while rst is held.
    #3;
    check("rst in_ready", 8'(in_ready), 8'd1);
    check("rst out_valid", 8'(out_valid), 8'd0);
    check("rst out_sum", out_sum, 8'h00);
    check("rst out_overflow", 8'(out_overflow), 8'd0);
    check("rst busy", 8'(busy), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table frames, back-to-back.
    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("vec%0d", k), tbl[k]);
    end

    // Result held stable under back-pressure; in_valid ignored in DONE.
    for (int i = 0; i < 4; i++) accept(8'(i + 1));
    in_valid  = 1'b1;
    in_data   = 8'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold out_valid", 8'(out_valid), 8'd1);
      check("hold out_sum", out_sum, 8'd10);
      check("hold out_overflow", 8'(out_overflow), 8'd0);
      check("hold in_ready", 8'(in_ready), 8'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold release in_ready", 8'(in_ready), 8'd1);
    check("hold release out_valid", 8'(out_valid), 8'd0);
    check("hold release busy", 8'(busy), 8'd0);

    // Mid-frame asynchronous reset discards the partial frame.
    accept(8'd5);
    accept(8'd6);
    check("pre-rst busy", 8'(busy), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", 8'(busy), 8'd0);
    check("async rst out_valid", 8'(out_valid), 8'd0);
    check("async rst out_sum", out_sum, 8'h00);
    check("async rst in_ready", 8'(in_ready), 8'd1);
    tick();
    rst = 1'b0;
    run_frame("post-rst", mk(1, 1, 1, 1, 8'h04, 1'b0));

    // Clear with a simultaneous accept drops that sample and the frame.
    accept(8'd50);
    accept(8'd50);
    accept(8'd50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear busy", 8'(busy), 8'd0);
    check("clear out_valid", 8'(out_valid), 8'd0);
    run_frame("post-clear", mk(2, 3, 4, 5, 14, 1'b0));

    // Clear in DONE drops out_valid without a handshake, even with out_ready high.
    for (int i = 0; i < 4; i++) accept(8'd100);
    check("done pre-clear out_valid", 8'(out_valid), 8'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    check("done clear out_valid", 8'(out_valid), 8'd0);
    check("done clear out_sum", out_sum, 8'h00);
    check("done clear in_ready", 8'(in_ready), 8'd1);
    run_frame("post-done-clear", mk(-5, 3, -2, 1, -3, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/signed_accumulator.md
SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 Parameter COUNT, default 4: number of signed 8-bit samples summed per frame; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous abort of the current frame.
REQ-005 in_valid  input  1  in_data holds a sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  8  two's-complement sample.
REQ-008 out_valid  output  1  frame result available.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_sum  output  8  two's-complement frame sum, modulo 2^8.
REQ-011 out_overflow  output  1  sticky signed-overflow flag for the frame.
REQ-012 busy  output  1  at least one sample accepted in the current, not yet completed, frame.

Function
REQ-013 The block SHALL have two states, ACCUM and DONE, and SHALL leave reset in ACCUM.
REQ-014 in_ready SHALL be 1 in ACCUM and 0 in DONE; out_valid SHALL be 1 exactly in DONE.
REQ-015 A sample SHALL be accepted when in_valid and in_ready are both 1 on a rising edge and clear is 0.
REQ-016 On accept: acc <= acc + in_data, truncated to 8 bits with no saturation, and the sample counter SHALL increment.
REQ-017 On accept: ovf <= ovf OR (acc[7] == in_data[7] AND new_acc[7] != acc[7]).
REQ-018 ovf SHALL remain set for the rest of the frame, even if later samples bring the true sum back into range.
REQ-019 When the COUNT-th sample is accepted, the state SHALL become DONE on that same edge.
REQ-020 out_valid SHALL therefore rise in the cycle after the last accept (latency 1).
REQ-021 In DONE, out_sum SHALL equal acc and out_overflow SHALL equal ovf, both stable while out_valid=1 and out_ready=0.
REQ-022 In DONE with out_ready=1, the next state SHALL be ACCUM, with acc, ovf and the counter cleared to 0.
REQ-023 In DONE, in_valid SHALL be ignored and no sample SHALL be consumed.
REQ-024 clear=1 SHALL force the ACCUM state and zero acc, ovf and the counter on the next edge, in any state.
REQ-025 clear=1 SHALL override a simultaneous accept and a simultaneous out_ready handshake.
REQ-026 clear=1 in DONE SHALL drop out_valid without a handshake.
REQ-027 busy SHALL be 1 iff state=ACCUM and counter != 0.
REQ-028 out_sum and out_overflow SHALL be 0 whenever out_valid=0.
REQ-029 A back-to-back frame SHALL be possible: the first sample of the next frame may be accepted in the cycle after the out handshake.

Reset
REQ-030 While rst=1, asynchronously: state=ACCUM; acc=0, ovf=0, counter=0; in_ready=1, out_valid=0, out_sum=0x00, out_overflow=0, busy=0.
REQ-031 rst asserted mid-frame or in DONE SHALL discard all partial or pending results; no out_valid SHALL follow for that frame.
REQ-032 The first accept after reset SHALL be possible on the first rising edge where rst=0.

Verification (COUNT=4)
REQ-033 Samples 10, 20, 30, 40 with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=0x64, out_overflow=0.
REQ-034 Samples 100, 50, -100, 0 -> out_sum=0x32, out_overflow=1 (overflow at steps 2 and 3).
REQ-035 Samples -128, -1, 1, 0 -> out_sum=0x80, out_overflow=1 (sticky, although the true sum of -128 fits).
REQ-036 Frame completes, then out_ready=0 for 3 cycles -> out_valid, out_sum and out_overflow stay stable and in_ready=0; out_ready=1 -> in_ready=1 on the next cycle.
REQ-037 Accept 2 samples (5, 6), then pulse rst -> all outputs zero and busy=0; then 1, 1, 1, 1 -> out_sum=0x04.
REQ-038 Accept 3 samples, then clear=1 and in_valid=1 in the same cycle -> sample discarded, busy=0; next 4 samples sum independently.
